// File: rtl/cpu_pkg.sv
// Shared fetch-unit types: FSM state encodings, buffer entry layout, reset PC.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cpu_pkg;

   // Fetch controller state encodings
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_HALT = 2'd2
   } fetch_state_t;

   // Default PC loaded on reset
   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

   // Fetch buffer depth for this release
   localparam int FBUF_DEPTH = 2;

   // One fetched instruction together with the byte PC it came from
   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } fetch_ent_t;

endpackage

// File: rtl/fetch_buf.sv
// Two-entry in-order fetch buffer with push, pop and flush; head is always entry 0.
// Latency: a pushed entry is visible at the head the cycle after the push edge.
// Backpressure: the caller must not push when full unless it pops in the same cycle; flush wins over push/pop.
module fetch_buf
   import cpu_pkg::*;
#(
   parameter int DEPTH = FBUF_DEPTH
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       i_push,
   input  fetch_ent_t i_push_dat,
   input  logic       i_pop,
   input  logic       i_flush,
   output logic       o_vld,
   output fetch_ent_t o_head_dat,
   output logic [1:0] o_count
);

   localparam logic [1:0] FULL = 2'(DEPTH);

   fetch_ent_t r_ent0;
   fetch_ent_t r_ent1;
   logic [1:0] r_count;
   logic       w_pop;
   logic       w_push;

   // A pop on an empty buffer is meaningless; a push into a full buffer is only legal alongside a pop
   assign w_pop  = i_pop && (r_count != 2'd0);
   assign w_push = i_push && ((r_count != FULL) || w_pop);

   // Shift-register FIFO: entry 0 is the head, entry 1 the tail when two are held
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_ent0  <= '0;
         r_ent1  <= '0;
         r_count <= 2'd0;
      end else if (i_flush) begin
         r_count <= 2'd0;
      end else begin
         case ({w_push, w_pop})
            2'b10: begin
               if (r_count == 2'd0) r_ent0 <= i_push_dat;
               else                 r_ent1 <= i_push_dat;
               r_count <= r_count + 2'd1;
            end
            2'b01: begin
               r_ent0  <= r_ent1;
               r_count <= r_count - 2'd1;
            end
            2'b11: begin
               if (r_count == 2'd1) begin
                  r_ent0 <= i_push_dat;
               end else begin
                  r_ent0 <= r_ent1;
                  r_ent1 <= i_push_dat;
               end
            end
            default: ;
         endcase
      end
   end

   assign o_vld      = (r_count != 2'd0);
   assign o_head_dat = r_ent0;
   assign o_count    = r_count;

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: IDLE/RUN/HALT FSM, PC sequencing, redirect flush, 2-entry fetch buffer.
// Latency: one cycle from fetch edge to out_valid; first fetch one cycle after entering RUN.
// Backpressure: out_ready low stalls the head; fetching stops when the buffer is full and not popping.
module fetch_ctrl
   import cpu_pkg::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
   parameter int          DEPTH    = FBUF_DEPTH
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        halt_req,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic [10:0] imem_addr,
   input  logic [31:0] imem_instr,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_pc,
   output logic [31:0] out_instr,
   output logic        busy
);

   localparam logic [1:0] FULL = 2'(DEPTH);

   fetch_state_t r_state;
   logic [31:0]  r_pc;
   logic         r_busy;

   logic         w_vld;
   logic [1:0]   w_count;
   logic         w_pop;
   logic         w_fetch;
   fetch_ent_t   w_push_dat;
   fetch_ent_t   w_head;

   // A redirect flushes the buffer, so the pop side is suppressed in that cycle
   assign w_pop = w_vld && out_ready && !redirect_valid;

   // Fetch only while running, not redirecting or halting, and only if there is room (or room is being freed)
   assign w_fetch = (r_state == ST_RUN) && !redirect_valid && !halt_req &&
                    ((w_count < FULL) || ((w_count == FULL) && w_pop));

   assign w_push_dat.pc    = r_pc;
   assign w_push_dat.instr = imem_instr;

   fetch_buf #(
      .DEPTH (DEPTH)
   ) u_buf (
      .clk        (clk),
      .rst        (rst),
      .i_push     (w_fetch),
      .i_push_dat (w_push_dat),
      .i_pop      (w_pop),
      .i_flush    (redirect_valid),
      .o_vld      (w_vld),
      .o_head_dat (w_head),
      .o_count    (w_count)
   );

   // State machine plus PC sequencing; busy is registered alongside the state
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_IDLE;
         r_busy  <= 1'b0;
         r_pc    <= RESET_PC;
      end else begin
         case (r_state)
            ST_IDLE, ST_HALT: begin
               if (start) begin
                  r_state <= ST_RUN;
                  r_busy  <= 1'b1;
               end
            end
            ST_RUN: begin
               if (halt_req) begin
                  r_state <= ST_HALT;
                  r_busy  <= 1'b0;
               end
            end
            default: begin
               r_state <= ST_IDLE;
               r_busy  <= 1'b0;
            end
         endcase

         // Redirect target is forced word-aligned; it takes priority over sequential fetch
         if (redirect_valid)
            r_pc <= redirect_pc & ~32'h0000_0003;
         else if (w_fetch)
            r_pc <= r_pc + 32'd4;
      end
   end

   assign imem_addr = r_pc[12:2];
   assign out_valid = w_vld;
   assign out_pc    = w_head.pc;
   assign out_instr = w_head.instr;
   assign busy      = r_busy;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Scoreboard bench for fetch_ctrl: stimulus pushes expected {pc,instr}, a negedge monitor pops and compares.
// Latency: n/a.
// Backpressure: out_ready is driven by the stimulus to create stalls and drains.
module tb_fetch_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic        halt_req;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic [10:0] imem_addr;
   logic [31:0] imem_instr;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_pc;
   logic [31:0] out_instr;
   logic        busy;

   logic [31:0] mem [0:2047];

   typedef struct {
      logic [31:0] pc;
      logic [31:0] instr;
   } exp_t;

   exp_t q[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   always #5 clk = ~clk;

   assign imem_instr = mem[imem_addr];

   fetch_ctrl dut (
      .clk            (clk),
      .rst            (rst),
      .start          (start),
      .halt_req       (halt_req),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .imem_addr      (imem_addr),
      .imem_instr     (imem_instr),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_pc         (out_pc),
      .out_instr      (out_instr),
      .busy           (busy)
   );

   // Memory content pattern: word i holds C0DE_0000 | i
   function automatic logic [31:0] mw(input logic [10:0] a);
      return 32'hC0DE_0000 | {21'd0, a};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic exp_push(input logic [31:0] pc);
      exp_t e;
      logic [10:0] wa;
      wa      = pc[12:2];
      e.pc    = pc;
      e.instr = mw(wa);
      q.push_back(e);
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      start = 1'b0; halt_req = 1'b0; redirect_valid = 1'b0;
      redirect_pc = 32'd0; out_ready = 1'b0;
      q.delete();
      tick(2);
      rst = 1'b0;
      tick(1);
   endtask

   // Accept outputs until every expected entry has been seen; report cycles taken
   task automatic drain(output int n);
      n = 0;
      out_ready = 1'b1;
      while (q.size() != 0 && n < 60) begin
         @(posedge clk);
         n++;
      end
      #1;
      if (q.size() != 0) begin
         n_checks++;
         n_fail++;
         $display("FAIL drain_timeout: got %0d entries pending expected 0", q.size());
         q.delete();
      end
      out_ready = 1'b0;
   endtask

   // Monitor: every handshake must match the head of the expected queue
   always @(negedge clk) begin
      exp_t e;
      if (!rst && out_valid && out_ready) begin
         if (q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_out: got pc %h expected no output", out_pc);
         end else begin
            e = q.pop_front();
            chk("out_pc", out_pc, e.pc);
            chk("out_instr", out_instr, e.instr);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      for (int i = 0; i < 2048; i++) mem[i] = mw(11'(i));

      // Reset state
      do_reset();
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_imem_addr", 32'(imem_addr), 32'd0);
      chk("rst_out_pc", out_pc, 32'd0);
      chk("rst_out_instr", out_instr, 32'd0);

      // Streaming: pcs 0,4,8,12 one per cycle, valid from cycle 2
      for (int p = 0; p < 16; p += 4) exp_push(32'(p));
      out_ready = 1'b1;
      start = 1'b1;
      tick(1);
      start = 1'b0;
      chk("s1_busy", 32'(busy), 32'd1);
      @(negedge clk);
      chk("s1_valid_cycle1", 32'(out_valid), 32'd0);
      @(negedge clk);
      chk("s1_valid_cycle2", 32'(out_valid), 32'd1);
      @(posedge clk);
      #1;
      drain(n);
      chk("s1_cycles", 32'(n), 32'd3);

      // Stall: buffer saturates at 2, pc stops at 8, release drains without gap
      do_reset();
      start = 1'b1;
      tick(1);
      start = 1'b0;
      tick(5);
      chk("s2_valid", 32'(out_valid), 32'd1);
      chk("s2_head_pc", out_pc, 32'd0);
      chk("s2_head_instr", out_instr, mw(11'd0));
      chk("s2_pc_stop", 32'(imem_addr), 32'd2);
      exp_push(32'd0); exp_push(32'd4); exp_push(32'd8);
      drain(n);
      chk("s2_cycles", 32'(n), 32'd3);

      // Redirect with two entries buffered
      do_reset();
      start = 1'b1;
      tick(1);
      start = 1'b0;
      tick(3);
      redirect_valid = 1'b1;
      redirect_pc = 32'h0000_0103;
      tick(1);
      redirect_valid = 1'b0;
      chk("s3_flush_valid", 32'(out_valid), 32'd0);
      chk("s3_redir_addr", 32'(imem_addr), 32'd64);
      exp_push(32'h0000_0100);
      drain(n);
      // Redirect together with halt: both apply
      redirect_valid = 1'b1;
      redirect_pc = 32'h0000_0200;
      halt_req = 1'b1;
      tick(1);
      redirect_valid = 1'b0;
      halt_req = 1'b0;
      chk("s3_halt_busy", 32'(busy), 32'd0);
      chk("s3_halt_valid", 32'(out_valid), 32'd0);
      chk("s3_halt_addr", 32'(imem_addr), 32'h80);
      tick(3);
      chk("s3_halt_nofetch", 32'(out_valid), 32'd0);
      chk("s3_halt_pc", 32'(imem_addr), 32'h80);

      // Redirect with start from IDLE, then wrap of the 11-bit word address
      do_reset();
      start = 1'b1;
      redirect_valid = 1'b1;
      redirect_pc = 32'h0000_1FF8;
      tick(1);
      start = 1'b0;
      redirect_valid = 1'b0;
      chk("s4_busy", 32'(busy), 32'd1);
      chk("s4_addr", 32'(imem_addr), 32'd2046);
      chk("s4_valid", 32'(out_valid), 32'd0);
      exp_push(32'h0000_1FF8); exp_push(32'h0000_1FFC);
      exp_push(32'h0000_2000); exp_push(32'h0000_2004);
      drain(n);
      chk("s4_cycles", 32'(n), 32'd5);

      // Halt with two buffered: drain, no new pushes, then resume at next pc
      do_reset();
      start = 1'b1;
      tick(1);
      start = 1'b0;
      tick(3);
      halt_req = 1'b1;
      tick(1);
      halt_req = 1'b0;
      chk("s5_busy", 32'(busy), 32'd0);
      exp_push(32'd0); exp_push(32'd4);
      drain(n);
      chk("s5_cycles", 32'(n), 32'd2);
      out_ready = 1'b1;
      tick(3);
      chk("s5_empty", 32'(out_valid), 32'd0);
      chk("s5_pc_hold", 32'(imem_addr), 32'd2);
      exp_push(32'd8); exp_push(32'd12);
      start = 1'b1;
      tick(1);
      start = 1'b0;
      chk("s5_resume_busy", 32'(busy), 32'd1);
      drain(n);
      halt_req = 1'b1;
      tick(1);
      halt_req = 1'b0;

      // Asynchronous reset between edges mid-run
      do_reset();
      start = 1'b1;
      tick(1);
      start = 1'b0;
      exp_push(32'd0); exp_push(32'd4);
      drain(n);
      tick(2);
      chk("s6_pre_pc", out_pc, 32'd8);
      #3;
      rst = 1'b1;
      #1;
      chk("s6_async_valid", 32'(out_valid), 32'd0);
      chk("s6_async_busy", 32'(busy), 32'd0);
      chk("s6_async_pc", out_pc, 32'd0);
      chk("s6_async_instr", out_instr, 32'd0);
      chk("s6_async_addr", 32'(imem_addr), 32'd0);
      tick(1);
      #3;
      rst = 1'b0;
      out_ready = 1'b1;
      tick(4);
      chk("s6_post_valid", 32'(out_valid), 32'd0);
      chk("s6_post_busy", 32'(busy), 32'd0);
      out_ready = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 SHALL provide parameter RESET_PC, default 32'h0000_0000, PC loaded on reset.
REQ-002 SHALL provide parameter DEPTH, default 2, fetch buffer entries (fixed at 2 for this release).
REQ-003 SHALL have port clk  input  1  single system clock, rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port start  input  1  pulse; IDLE or HALT -> RUN.
REQ-006 SHALL have port halt_req  input  1  pulse; stop fetching after current cycle.
REQ-007 SHALL have port redirect_valid  input  1  branch/jump redirect request.
REQ-008 SHALL have port redirect_pc  input  32  redirect target byte address.
REQ-009 SHALL have port imem_addr  output  11  word address to instruction memory, = pc[12:2].
REQ-010 SHALL have port imem_instr  input  32  combinational instruction-memory read data for imem_addr.
REQ-011 SHALL have port out_valid  output  1  buffer head holds a valid instruction.
REQ-012 SHALL have port out_ready  input  1  decode stage accepts head this cycle.
REQ-013 SHALL have port out_pc  output  32  byte PC of head entry.
REQ-014 SHALL have port out_instr  output  32  instruction word of head entry.
REQ-015 SHALL have port busy  output  1  high when state is RUN.

Function
REQ-016 SHALL implement states IDLE, RUN, HALT; reset state IDLE.
REQ-017 IDLE/HALT --start--> RUN; RUN --halt_req--> HALT; no other transitions except reset.
REQ-018 Fetch condition: state RUN and no redirect_valid and (count<2 or (count==2 and pop)); pop = out_valid and out_ready.
REQ-019 On fetch, SHALL push {pc, imem_instr} into buffer and set pc <= pc+4 at the same edge (one-cycle fetch latency; out_valid high the cycle after the first fetch).
REQ-020 pc+4 SHALL wrap modulo 2^32; imem_addr SHALL wrap naturally modulo 2048 words.
REQ-021 Buffer SHALL be FIFO order; out_* SHALL reflect head entry; out_pc/out_instr held stable while out_valid and not out_ready.
REQ-022 Simultaneous push and pop at count==2 SHALL keep count 2 with correct order; push+pop at count==1 keeps count 1.
REQ-023 redirect_valid (any state) SHALL flush buffer (count<=0, out_valid low next cycle), set pc <= {redirect_pc[31:2],2'b00}, and suppress fetch and pop-side effects that cycle.
REQ-024 redirect_valid with halt_req same cycle: flush and pc load both apply; state goes to HALT.
REQ-025 redirect_valid with start same cycle in IDLE/HALT: pc loaded, state RUN, first fetch next cycle.
REQ-026 In HALT/IDLE, buffer SHALL continue draining via out_ready; no pushes.
REQ-027 halt_req SHALL block fetch in the same cycle it is asserted.
REQ-028 busy SHALL be 1 exactly in RUN.

Reset
REQ-029 rst asserted SHALL immediately set state IDLE, pc RESET_PC, count 0, out_valid 0, out_pc 0, out_instr 0, busy 0, imem_addr RESET_PC[12:2], regardless of clk.
REQ-030 Reset mid-operation SHALL discard all buffered entries; no entry emerges after reset release until start.

Structure
REQ-031 State encodings and RESET_PC default SHALL reside in shared package cpu_pkg.
REQ-032 Buffer SHALL be sub-module fetch_buf (2-entry FIFO, push/pop/flush, count output).
REQ-033 Instruction memory SHALL remain external, connected via imem_addr/imem_instr.

Verification
REQ-034 Reset then start, out_ready=1, mem[0..3]=A0,A1,A2,A3 -> out_valid from cycle 2, out_pc 0,4,8,12 with instrs A0..A3, one per cycle.
REQ-035 out_ready=0 for 5 cycles after start -> count saturates at 2, pc stops at 8, head stays pc 0; release -> pcs 0,4,8 with no gap or duplicate.
REQ-036 redirect_valid with redirect_pc=32'h0000_0103 while 2 entries buffered -> out_valid 0 next cycle, next out_pc 32'h100, instr mem[64].
REQ-037 pc=32'h0000_1FFC fetching -> imem_addr 2047 then 0, out_pc 32'h1FFC then 32'h2000.
REQ-038 halt_req with 2 entries buffered -> state HALT, busy 0, both entries drain, no new push; start -> fetch resumes at next pc.
REQ-039 rst asserted asynchronously mid-RUN between edges -> all outputs at reset values immediately; after release out_valid stays 0 until start.
